exception_unit: RTL

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exception_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/exception_unit.sv
// Pipeline exception capture: prioritises stage requests, holds the report for the coprocessor,
// then flushes and waits in KERNEL for eret. EXC_BADADDR_EN adds the bad-address field.
module exception_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_ri,
  input  logic        id_syscall,
  input  logic [31:0] id_pc,
  input  logic        ex_ovf,
  input  logic [31:0] ex_pc,
`ifdef EXC_BADADDR_EN
  input  logic [31:0] mem_badaddr,
`endif
  input  logic        cop_ack,
  input  logic        eret,
  output logic [66:0] exception_bus,
  output logic        flush,
  output logic        busy,
  output logic        panic,
  output logic        double_fault
);

  typedef enum logic [1:0] {StIdle, StReport, StFlush, StKernel} state_e;

  state_e      state_q, state_d;
  logic [66:0] bus_q, bus_d;
  logic        flush_q, flush_d;
  logic        busy_q;
  logic        panic_q, panic_d;
  logic        dfault_q, dfault_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req;
  logic [31:0] bad_addr;

  assign req = !stall && (ex_ovf || id_ri || id_syscall);

`ifdef EXC_BADADDR_EN
  assign bad_addr = mem_badaddr;
`else
  assign bad_addr = 32'h0;
`endif

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    flush_d  = 1'b0;
    panic_d  = panic_q;
    dfault_d = dfault_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StReport;
          cnt_d   = 4'd0;
          if (ex_ovf)     bus_d = {3'b100, ex_pc, bad_addr};
          else if (id_ri) bus_d = {3'b010, id_pc, bad_addr};
          else            bus_d = {3'b001, id_pc, bad_addr};
        end
      end
      StReport: begin
        if (req) dfault_d = 1'b1;
        if (cop_ack) begin
          state_d = StFlush;
          bus_d   = '0;
          flush_d = 1'b1;
        end else if (cnt_q == 4'd14) begin
          // Fifteenth unacknowledged cycle: counter saturates at 15 as we give up.
          state_d = StFlush;
          bus_d   = '0;
          flush_d = 1'b1;
          panic_d = 1'b1;
          cnt_d   = 4'd15;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StFlush: begin
        if (req) dfault_d = 1'b1;
        state_d = StKernel;
      end
      StKernel: begin
        if (req) dfault_d = 1'b1;
        if (eret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      bus_q    <= '0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      panic_q  <= 1'b0;
      dfault_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      flush_q  <= flush_d;
      busy_q   <= (state_d != StIdle);
      panic_q  <= panic_d;
      dfault_q <= dfault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign exception_bus = bus_q;
  assign flush         = flush_q;
  assign busy          = busy_q;
  assign panic         = panic_q;
  assign double_fault  = dfault_q;

endmodule
